gpr_access_controller: RTL

Initiator side of the general-purpose register file: accepts operand-read and result-write requests from the CPU sequencer via valid/ready handshakes and drives the register file's two ports. Its sequencing accounts for the one-cycle synchronous read latency. It enforces the ECO32 zero-register rule: r0 reads as 0 and writes to r0 are dropped. It sits between the CPU control FSM and the dual-port 32x32 register memory.

---
 rtl/gpr_pkg.sv | 23 ++
 rtl/gpr_access_controller.sv | 134 +++++++++++++
 2 files changed

// File: rtl/gpr_pkg.sv
// +----------------------------------------------------------------------+
// | gpr_pkg: shared constants and state encoding for the GPR controller  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package gpr_pkg;

    localparam int GPR_COUNT       = 32;
    localparam int GPR_INDEX_WIDTH = 5;
    localparam int GPR_DATA_WIDTH  = 32;
    localparam logic [GPR_INDEX_WIDTH-1:0] GPR_ZERO_INDEX = '0;

    typedef enum logic [1:0] {
        CLEAR     = 2'd0,
        IDLE      = 2'd1,
        READ_WAIT = 2'd2,
        RESPOND   = 2'd3
    } gpr_access_state_t;

endpackage

`default_nettype wire

// File: rtl/gpr_access_controller.sv
// +----------------------------------------------------------------------+
// | gpr_access_controller: handshaked operand-read / result-write front  |
// | end for the dual-port register file, with r0 forced to zero.         |
// | Optional macro GPR_CLEAR_ON_RESET_EN zero-fills r0..r31 after reset. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module gpr_access_controller
    import gpr_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       readRequestValid,
    output logic                       readRequestReady,
    input  logic [GPR_INDEX_WIDTH-1:0] readIndexA,
    input  logic [GPR_INDEX_WIDTH-1:0] readIndexB,
    output logic                       readResponseValid,
    input  logic                       readResponseReady,
    output logic [GPR_DATA_WIDTH-1:0]  readDataA,
    output logic [GPR_DATA_WIDTH-1:0]  readDataB,
    input  logic                       writeRequestValid,
    output logic                       writeRequestReady,
    input  logic [GPR_INDEX_WIDTH-1:0] writeIndex,
    input  logic [GPR_DATA_WIDTH-1:0]  writeData,
    output logic [GPR_INDEX_WIDTH-1:0] gprIndex1,
    input  logic [GPR_DATA_WIDTH-1:0]  gprReadData1,
    output logic [GPR_INDEX_WIDTH-1:0] gprIndex2,
    input  logic [GPR_DATA_WIDTH-1:0]  gprReadData2,
    output logic [GPR_DATA_WIDTH-1:0]  gprWriteData2,
    output logic                       gprWriteEnable2
);

    gpr_access_state_t                state;
    gpr_access_state_t                state_next;
    logic [GPR_INDEX_WIDTH-1:0]       captured_index_a;
    logic [GPR_INDEX_WIDTH-1:0]       captured_index_b;
    logic [GPR_DATA_WIDTH-1:0]        data_a;
    logic [GPR_DATA_WIDTH-1:0]        data_b;
    logic                             read_accept;
    logic                             write_enable;

`ifdef GPR_CLEAR_ON_RESET_EN
    localparam gpr_access_state_t RESET_STATE = CLEAR;
    logic [GPR_INDEX_WIDTH-1:0]       clear_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clear_count <= '0;
        end else if (state == CLEAR) begin
            clear_count <= clear_count + 1'b1;
        end
    end
`else
    localparam gpr_access_state_t RESET_STATE = IDLE;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= RESET_STATE;
            captured_index_a <= '0;
            captured_index_b <= '0;
            data_a           <= '0;
            data_b           <= '0;
        end else begin
            state <= state_next;
            if (read_accept) begin
                captured_index_a <= readIndexA;
                captured_index_b <= readIndexB;
            end
            // RAM output is valid one cycle after accept; mask r0 here.
            if (state == READ_WAIT) begin
                data_a <= (captured_index_a == GPR_ZERO_INDEX) ? '0 : gprReadData1;
                data_b <= (captured_index_b == GPR_ZERO_INDEX) ? '0 : gprReadData2;
            end
        end
    end

    always_comb begin
        state_next        = state;
        readRequestReady  = 1'b0;
        writeRequestReady = 1'b0;
        readResponseValid = 1'b0;
        gprIndex1         = readIndexA;
        gprIndex2         = readIndexB;
        gprWriteData2     = writeData;
        write_enable      = 1'b0;
        read_accept       = 1'b0;
        case (state)
`ifdef GPR_CLEAR_ON_RESET_EN
            CLEAR: begin
                gprIndex1     = clear_count;
                gprIndex2     = clear_count;
                gprWriteData2 = '0;
                write_enable  = 1'b1;
                if (clear_count == GPR_INDEX_WIDTH'(GPR_COUNT - 1)) begin
                    state_next = IDLE;
                end
            end
`endif
            IDLE: begin
                writeRequestReady = 1'b1;
                readRequestReady  = ~writeRequestValid;
                if (writeRequestValid) begin
                    gprIndex2    = writeIndex;
                    write_enable = (writeIndex != GPR_ZERO_INDEX);
                end else if (readRequestValid) begin
                    read_accept = 1'b1;
                    state_next  = READ_WAIT;
                end
            end
            READ_WAIT: begin
                state_next = RESPOND;
            end
            RESPOND: begin
                readResponseValid = 1'b1;
                if (readResponseReady) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Keeps the RAM untouched while reset is held, whatever the request inputs do.
    assign gprWriteEnable2 = write_enable & ~reset;
    assign readDataA       = data_a;
    assign readDataB       = data_b;

endmodule

`default_nettype wire
